// File: rtl/reg_bank_writer.sv
// rtl/reg_bank_writer.sv - MEM/WB stage register and 13 x 26-bit write-back register bank
// Optional read bypass from the stage register: define REGBANK_BYPASS_EN.
module reg_bank_writer #(
  parameter int DATA_W = 26,
  parameter int NREGS  = 13,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] bank_out [NREGS-1:0],
  output logic              pend_valid,
  output logic              addr_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  logic [DATA_W-1:0] r_bank [NREGS-1:0];
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_pend_data;
  logic              r_addr_err;

  logic              w_wb_illegal;
  logic              w_pend_writable;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  assign w_wb_illegal = wb_addr > LAST_ADDR;
  // R0 and out-of-range entries ride through the stage but never reach the array.
  assign w_pend_writable = r_pend_valid && (r_pend_addr != '0) && (r_pend_addr <= LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_bank[i] <= '0;
      end
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_addr_err   <= 1'b0;
    end else if (flush) begin
      r_pend_valid <= 1'b0;
    end else if (!stall) begin
      for (int i = 1; i < NREGS; i++) begin
        if (w_pend_writable && (r_pend_addr == ADDR_W'(i))) begin
          r_bank[i] <= r_pend_data;
        end
      end
      r_pend_valid <= wb_valid;
      r_pend_addr  <= wb_addr;
      r_pend_data  <= wb_data;
      if (wb_valid && w_wb_illegal) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (ra1 == ADDR_W'(i)) w_rd1 = r_bank[i];
      if (ra2 == ADDR_W'(i)) w_rd2 = r_bank[i];
    end
`ifdef REGBANK_BYPASS_EN
    if (w_pend_writable && (r_pend_addr == ra1)) w_rd1 = r_pend_data;
    if (w_pend_writable && (r_pend_addr == ra2)) w_rd2 = r_pend_data;
`else
`endif
  end

  assign rd1        = w_rd1;
  assign rd2        = w_rd2;
  assign bank_out   = r_bank;
  assign pend_valid = r_pend_valid;
  assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_reg_bank_writer.sv
// tb/tb_reg_bank_writer.sv - randomized self-checking bench for reg_bank_writer with a behavioural bank model
module tb_reg_bank_writer;

  logic        clk, rst;
  logic        wb_valid, stall, flush;
  logic [3:0]  wb_addr, ra1, ra2;
  logic [25:0] wb_data, rd1, rd2;
  logic [25:0] bank_out [12:0];
  logic        pend_valid, addr_err;

  int n_pass = 0;
  int n_total = 0;

  reg_bank_writer dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .flush(flush), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .bank_out(bank_out), .pend_valid(pend_valid), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: architectural bank plus the one in-flight write, updated by the rules of operation.
  logic [25:0] m_bank [13];
  logic        m_pv, m_err;
  logic [3:0]  m_pa;
  logic [25:0] m_pd;

  task automatic m_reset();
    foreach (m_bank[i]) m_bank[i] = '0;
    m_pv = 0; m_pa = 0; m_pd = 0; m_err = 0;
  endtask

  task automatic m_edge(input logic v, input logic [3:0] a, input logic [25:0] d,
                        input logic st, input logic fl);
    if (fl) begin
      m_pv = 0;
    end else if (!st) begin
      if (m_pv && m_pa >= 1 && m_pa <= 12) m_bank[m_pa] = m_pd;
      m_pv = v; m_pa = a; m_pd = d;
      if (v && a >= 13) m_err = 1;
    end
  endtask

  function automatic logic [25:0] exp_rd(input logic [3:0] ra);
`ifdef REGBANK_BYPASS_EN
    if (m_pv && m_pa == ra && ra >= 1 && ra <= 12) return m_pd;
`endif
    return (ra >= 1 && ra <= 12) ? m_bank[ra] : 26'd0;
  endfunction

  // Drive one cycle's inputs at the falling edge, let the rising edge happen, return at the next falling edge.
  task automatic tick(input logic v, input logic [3:0] a, input logic [25:0] d,
                      input logic st, input logic fl);
    wb_valid = v; wb_addr = a; wb_data = d; stall = st; flush = fl;
    @(posedge clk);
    m_edge(v, a, d, st, fl);
    @(negedge clk);
  endtask

  task automatic test_reset();
    ra1 = 4'd5; ra2 = 4'd5;
    tick(1, 4'd5, 26'h0000123, 0, 0);
    tick(0, 4'd0, 26'h0, 0, 0);
    n_total++;
    if (bank_out[5] !== 26'h0000123) $display("FAIL reset_pre_r5 got %h exp %h", bank_out[5], 26'h0000123);
    else n_pass++;
    #2 rst = 1'b1;
    m_reset();
    #1;
    for (int i = 0; i < 13; i++) begin
      n_total++;
      if (bank_out[i] !== 26'h0) $display("FAIL reset_bank[%0d] got %h exp 0", i, bank_out[i]);
      else n_pass++;
    end
    n_total++;
    if (rd1 !== 26'h0 || rd2 !== 26'h0) $display("FAIL reset_rd got %h/%h exp 0/0", rd1, rd2);
    else n_pass++;
    n_total++;
    if (pend_valid !== 1'b0 || addr_err !== 1'b0)
      $display("FAIL reset_flags got pv=%b err=%b exp 0/0", pend_valid, addr_err);
    else n_pass++;
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_write();
    ra1 = 4'd3; ra2 = 4'd0;
    tick(1, 4'd3, 26'h3ABCDEF, 0, 0);
    n_total++;
    if (bank_out[3] !== 26'h0) $display("FAIL basic_bank_edge1 got %h exp 0", bank_out[3]);
    else n_pass++;
    n_total++;
`ifdef REGBANK_BYPASS_EN
    if (rd1 !== 26'h3ABCDEF) $display("FAIL basic_rd1_edge1 got %h exp %h", rd1, 26'h3ABCDEF);
`else
    if (rd1 !== 26'h0) $display("FAIL basic_rd1_edge1 got %h exp 0", rd1);
`endif
    else n_pass++;
    tick(0, 4'd0, 26'h0, 0, 0);
    n_total++;
    if (bank_out[3] !== 26'h3ABCDEF || rd1 !== 26'h3ABCDEF)
      $display("FAIL basic_edge2 got bank=%h rd1=%h exp %h", bank_out[3], rd1, 26'h3ABCDEF);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    ra1 = 4'd1; ra2 = 4'd2;
    tick(1, 4'd1, 26'h1, 0, 0);
    tick(1, 4'd2, 26'h2, 0, 0);
    n_total++;
    if (bank_out[1] !== 26'h1) $display("FAIL b2b_r1_first got %h exp 1", bank_out[1]);
    else n_pass++;
    tick(1, 4'd1, 26'h3, 0, 0);
    n_total++;
    if (bank_out[2] !== 26'h2) $display("FAIL b2b_r2 got %h exp 2", bank_out[2]);
    else n_pass++;
    tick(0, 4'd0, 26'h0, 0, 0);
    n_total++;
    if (bank_out[1] !== 26'h3 || bank_out[2] !== 26'h2)
      $display("FAIL b2b_final got r1=%h r2=%h exp 3/2", bank_out[1], bank_out[2]);
    else n_pass++;
  endtask

  task automatic test_stall_flush();
    ra1 = 4'd4; ra2 = 4'd6;
    tick(1, 4'd4, 26'h55, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 4'd0, 26'h0, 1, 0);
      n_total++;
      if (bank_out[4] !== 26'h0 || pend_valid !== 1'b1 || rd1 !== exp_rd(4'd4))
        $display("FAIL stall_hold%0d got bank=%h pv=%b rd1=%h exp 0/1/%h", k, bank_out[4], pend_valid, rd1, exp_rd(4'd4));
      else n_pass++;
    end
    tick(0, 4'd0, 26'h0, 0, 0);
    n_total++;
    if (bank_out[4] !== 26'h55) $display("FAIL stall_release got %h exp 55", bank_out[4]);
    else n_pass++;
    tick(1, 4'd6, 26'h66, 0, 0);
    tick(1, 4'd7, 26'h77, 1, 1);
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (bank_out[6] !== 26'h0 || bank_out[7] !== 26'h0 || pend_valid !== 1'b0 || rd2 !== 26'h0)
        $display("FAIL flush_drop%0d got r6=%h r7=%h pv=%b rd2=%h exp 0/0/0/0", k, bank_out[6], bank_out[7], pend_valid, rd2);
      else n_pass++;
      tick(0, 4'd0, 26'h0, 0, 0);
    end
  endtask

  task automatic test_r0_illegal();
    logic [25:0] snap [13];
    ra1 = 4'd0; ra2 = 4'd14;
    tick(1, 4'd0, 26'h3FFFFFF, 0, 0);
    n_total++;
    if (rd1 !== 26'h0) $display("FAIL r0_rd_edge1 got %h exp 0", rd1);
    else n_pass++;
    tick(0, 4'd0, 26'h0, 0, 0);
    n_total++;
    if (bank_out[0] !== 26'h0 || rd1 !== 26'h0) $display("FAIL r0_write got bank=%h rd1=%h exp 0/0", bank_out[0], rd1);
    else n_pass++;
    foreach (snap[i]) snap[i] = bank_out[i];
    n_total++;
    if (addr_err !== 1'b0) $display("FAIL illegal_pre_err got %b exp 0", addr_err);
    else n_pass++;
    tick(1, 4'd14, 26'h7, 0, 0);
    n_total++;
    if (addr_err !== 1'b1) $display("FAIL illegal_err_rise got %b exp 1", addr_err);
    else n_pass++;
    for (int k = 0; k < 3; k++) tick(0, 4'd0, 26'h0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      n_total++;
      if (bank_out[i] !== snap[i]) $display("FAIL illegal_bank[%0d] got %h exp %h", i, bank_out[i], snap[i]);
      else n_pass++;
    end
    n_total++;
    if (addr_err !== 1'b1 || rd2 !== 26'h0) $display("FAIL illegal_sticky got err=%b rd2=%h exp 1/0", addr_err, rd2);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] a;
    for (int c = 0; c < 400; c++) begin
      a = 4'($urandom_range(0, 15));
      ra1 = 4'($urandom_range(0, 15));
      ra2 = 4'($urandom_range(0, 15));
      tick(1'($urandom_range(0, 3) != 0), a, 26'($urandom), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 9) == 0));
      n_total++;
      if (rd1 !== exp_rd(ra1) || rd2 !== exp_rd(ra2))
        $display("FAIL rand_rd c%0d got %h/%h exp %h/%h", c, rd1, rd2, exp_rd(ra1), exp_rd(ra2));
      else n_pass++;
      n_total++;
      if (pend_valid !== m_pv || addr_err !== m_err)
        $display("FAIL rand_flags c%0d got pv=%b err=%b exp %b/%b", c, pend_valid, addr_err, m_pv, m_err);
      else n_pass++;
      for (int i = 0; i < 13; i++) begin
        n_total++;
        if (bank_out[i] !== m_bank[i]) $display("FAIL rand_bank[%0d] c%0d got %h exp %h", i, c, bank_out[i], m_bank[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    wb_valid = 0; wb_addr = 0; wb_data = 0; stall = 0; flush = 0; ra1 = 0; ra2 = 0;
    m_reset();
    #12 rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_write();
    test_back_to_back();
    test_stall_flush();
    test_r0_illegal();
    test_random();
    test_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
